// File: rtl/uart_pixel_packer.sv
// uart_pixel_packer: packs UART byte pairs into RGB444 pixel writes with raster addressing, frame sync, timeout and error count
// Ports: clk_uart/rst (sync, active-high); rx_data/rx_valid byte stream in;
// write_en/write_data/addr_wr pixel write out; frame_done on last-address write; err_cnt saturating discard count.
module uart_pixel_packer #(
  parameter int FRAME_PIXELS = 307200,
  parameter int ADDR_W       = 19,
  parameter int TIMEOUT_CYC  = 50000
) (
  input  logic              clk_uart,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              write_en,
  output logic [11:0]       write_data,
  output logic [ADDR_W-1:0] addr_wr,
  output logic              frame_done,
  output logic [7:0]        err_cnt
);
  localparam int TW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
  typedef enum logic {WAIT_HI, WAIT_LO} state_t;
  state_t            state_q, state_d;
  logic [7:0]        hi_q, hi_d, err_q, err_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d, addr_q, addr_d;
  logic [11:0]       data_q, data_d;
  logic              we_q, we_d, fd_q, fd_d;
  logic              lo_acc, is_pix, is_sync, is_bad, tmo, last_addr;
  assign lo_acc    = state_q == WAIT_LO && rx_valid;
  assign is_pix    = lo_acc && rx_data[7:4] == 4'h0;
  assign is_sync   = lo_acc && rx_data[7:4] == 4'hF;
  assign is_bad    = lo_acc && !is_pix && !is_sync;
  // a LO byte arriving on the expiry cycle takes priority over the timeout
  assign tmo       = state_q == WAIT_LO && !rx_valid && timer_q == TW'(TIMEOUT_CYC - 1);
  assign last_addr = next_addr_q == ADDR_W'(FRAME_PIXELS - 1);
  always_comb begin
    state_d     = state_q == WAIT_HI ? (rx_valid ? WAIT_LO : WAIT_HI) : ((rx_valid || tmo) ? WAIT_HI : WAIT_LO);
    hi_d        = (state_q == WAIT_HI && rx_valid) ? rx_data : hi_q;
    timer_d     = (state_q == WAIT_LO && !rx_valid) ? timer_q + TW'(1) : '0;
    we_d        = is_pix;
    fd_d        = is_pix && last_addr;
    data_d      = is_pix ? {hi_q, rx_data[3:0]} : data_q;
    addr_d      = is_pix ? next_addr_q : addr_q;
    next_addr_d = is_sync ? '0 : is_pix ? (last_addr ? '0 : next_addr_q + ADDR_W'(1)) : next_addr_q;
    err_d       = ((is_bad || tmo) && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end
  always_ff @(posedge clk_uart) begin
    if (rst) begin
      state_q     <= WAIT_HI;
      hi_q        <= '0;
      timer_q     <= '0;
      we_q        <= 1'b0;
      fd_q        <= 1'b0;
      data_q      <= '0;
      addr_q      <= '0;
      next_addr_q <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      timer_q     <= timer_d;
      we_q        <= we_d;
      fd_q        <= fd_d;
      data_q      <= data_d;
      addr_q      <= addr_d;
      next_addr_q <= next_addr_d;
      err_q       <= err_d;
    end
  end
  assign write_en   = we_q;
  assign write_data = data_q;
  assign addr_wr    = addr_q;
  assign frame_done = fd_q;
  assign err_cnt    = err_q;
endmodule

// File: tb/tb_uart_pixel_packer.sv
// tb_uart_pixel_packer: directed self-checking bench for uart_pixel_packer (4-pixel frame, 8-cycle timeout)
module tb_uart_pixel_packer;
  logic        clk_uart = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        write_en, frame_done;
  logic [11:0] write_data;
  logic [18:0] addr_wr;
  logic [7:0]  err_cnt;
  int checks = 0;
  int errors = 0;

  uart_pixel_packer #(.FRAME_PIXELS(4), .ADDR_W(19), .TIMEOUT_CYC(8)) dut (
    .clk_uart(clk_uart), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .write_en(write_en), .write_data(write_data), .addr_wr(addr_wr),
    .frame_done(frame_done), .err_cnt(err_cnt)
  );

  always #5 clk_uart = ~clk_uart;

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk_uart);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_uart);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    @(posedge clk_uart);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL reset_we got %0b exp 0", write_en); end
    checks++; if (write_data !== 12'h000) begin errors++; $display("FAIL reset_data got %h exp 000", write_data); end
    checks++; if (addr_wr !== 19'd0) begin errors++; $display("FAIL reset_addr got %0d exp 0", addr_wr); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd got %0b exp 0", frame_done); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err got %0d exp 0", err_cnt); end
  endtask

  task automatic test_stream();
    apply_reset();
    send(8'h12);
    checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL stream_hi_we got %0b exp 0", write_en); end
    send(8'h03);
    checks++; if (write_en !== 1'b1) begin errors++; $display("FAIL stream_we0 got %0b exp 1", write_en); end
    checks++; if (write_data !== 12'h123) begin errors++; $display("FAIL stream_data0 got %h exp 123", write_data); end
    checks++; if (addr_wr !== 19'd0) begin errors++; $display("FAIL stream_addr0 got %0d exp 0", addr_wr); end
    send(8'h45);
    checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL stream_we_one_cycle got %0b exp 0", write_en); end
    send(8'h06);
    checks++; if (write_en !== 1'b1) begin errors++; $display("FAIL stream_we1 got %0b exp 1", write_en); end
    checks++; if (write_data !== 12'h456) begin errors++; $display("FAIL stream_data1 got %h exp 456", write_data); end
    checks++; if (addr_wr !== 19'd1) begin errors++; $display("FAIL stream_addr1 got %0d exp 1", addr_wr); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL stream_err got %0d exp 0", err_cnt); end
    idle(1);
    checks++; if (write_data !== 12'h456 || addr_wr !== 19'd1) begin errors++; $display("FAIL stream_hold got %h/%0d exp 456/1", write_data, addr_wr); end
  endtask

  task automatic test_wrap();
    logic [18:0] ea [5] = '{19'd0, 19'd1, 19'd2, 19'd3, 19'd0};
    logic        ef [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [11:0] ed [5] = '{12'h201, 12'h212, 12'h223, 12'h234, 12'h245};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      send(8'h20 + 8'(i));
      send(8'h01 + 8'(i));
      checks++; if (write_en !== 1'b1 || write_data !== ed[i]) begin errors++; $display("FAIL wrap_data%0d got we=%0b %h exp we=1 %h", i, write_en, write_data, ed[i]); end
      checks++; if (addr_wr !== ea[i]) begin errors++; $display("FAIL wrap_addr%0d got %0d exp %0d", i, addr_wr, ea[i]); end
      checks++; if (frame_done !== ef[i]) begin errors++; $display("FAIL wrap_fd%0d got %0b exp %0b", i, frame_done, ef[i]); end
    end
    idle(1);
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL wrap_fd_pulse got %0b exp 0", frame_done); end
  endtask

  task automatic test_sync();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      send(8'h31);
      send(8'h05);
    end
    send(8'h00);
    send(8'hF0);
    checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL sync_no_write got %0b exp 0", write_en); end
    checks++; if (addr_wr !== 19'd2 || write_data !== 12'h315) begin errors++; $display("FAIL sync_hold got %0d/%h exp 2/315", addr_wr, write_data); end
    send(8'hAB);
    send(8'h0C);
    checks++; if (write_en !== 1'b1 || write_data !== 12'hABC) begin errors++; $display("FAIL sync_data got we=%0b %h exp we=1 ABC", write_en, write_data); end
    checks++; if (addr_wr !== 19'd0) begin errors++; $display("FAIL sync_addr got %0d exp 0", addr_wr); end
    checks++; if (frame_done !== 1'b0 || err_cnt !== 8'd0) begin errors++; $display("FAIL sync_fd_err got %0b/%0d exp 0/0", frame_done, err_cnt); end
  endtask

  task automatic test_bad_tag();
    apply_reset();
    send(8'h11);
    send(8'h52);
    checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL bad_no_write got %0b exp 0", write_en); end
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL bad_err1 got %0d exp 1", err_cnt); end
    for (int i = 0; i < 300; i++) begin
      send(8'h11);
      send(8'h52);
    end
    checks++; if (err_cnt !== 8'hFF) begin errors++; $display("FAIL bad_sat got %h exp FF", err_cnt); end
    checks++; if (write_data !== 12'h000 || addr_wr !== 19'd0) begin errors++; $display("FAIL bad_untouched got %h/%0d exp 000/0", write_data, addr_wr); end
    send(8'h12);
    send(8'h03);
    checks++; if (write_en !== 1'b1 || addr_wr !== 19'd0 || err_cnt !== 8'hFF) begin errors++; $display("FAIL bad_recover got we=%0b a=%0d e=%h exp 1/0/FF", write_en, addr_wr, err_cnt); end
  endtask

  task automatic test_timeout();
    apply_reset();
    send(8'h77);
    idle(7);
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL tmo_early got %0d exp 0", err_cnt); end
    idle(1);
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL tmo_err got %0d exp 1", err_cnt); end
    checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL tmo_no_write got %0b exp 0", write_en); end
    send(8'h12);
    send(8'h03);
    checks++; if (write_en !== 1'b1 || write_data !== 12'h123) begin errors++; $display("FAIL tmo_data got we=%0b %h exp we=1 123", write_en, write_data); end
    checks++; if (addr_wr !== 19'd0 || err_cnt !== 8'd1) begin errors++; $display("FAIL tmo_addr_err got %0d/%0d exp 0/1", addr_wr, err_cnt); end
    idle(1);
    checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL tmo_single_write got %0b exp 0", write_en); end
  endtask

  task automatic test_timeout_edge();
    apply_reset();
    send(8'h77);
    idle(7);
    send(8'h03);
    checks++; if (write_en !== 1'b1 || write_data !== 12'h773) begin errors++; $display("FAIL edge_data got we=%0b %h exp we=1 773", write_en, write_data); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL edge_err got %0d exp 0", err_cnt); end
    idle(1);
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL edge_err_late got %0d exp 0", err_cnt); end
  endtask

  task automatic test_reset_mid_pair();
    apply_reset();
    send(8'h11);
    send(8'h52);
    send(8'h56);
    send(8'h07);
    send(8'h99);
    rst = 1'b1;
    rx_data = 8'h03;
    rx_valid = 1'b1;
    @(posedge clk_uart);
    #1;
    checks++; if (write_en !== 1'b0 || write_data !== 12'h000 || addr_wr !== 19'd0 || frame_done !== 1'b0 || err_cnt !== 8'd0) begin errors++; $display("FAIL rstmid_during got we=%0b d=%h a=%0d fd=%0b e=%0d exp all 0", write_en, write_data, addr_wr, frame_done, err_cnt); end
    rst = 1'b0;
    rx_valid = 1'b0;
    idle(1);
    checks++; if (write_en !== 1'b0 || write_data !== 12'h000 || addr_wr !== 19'd0 || err_cnt !== 8'd0) begin errors++; $display("FAIL rstmid_after got we=%0b d=%h a=%0d e=%0d exp all 0", write_en, write_data, addr_wr, err_cnt); end
    send(8'h12);
    send(8'h03);
    checks++; if (write_en !== 1'b1 || write_data !== 12'h123 || addr_wr !== 19'd0) begin errors++; $display("FAIL rstmid_write got we=%0b %h a=%0d exp 1 123 0", write_en, write_data, addr_wr); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_wrap();
    test_sync();
    test_bad_tag();
    test_timeout();
    test_timeout_edge();
    test_reset_mid_pair();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
